// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial bit-pattern detector with overlapping/non-overlapping modes.
// Define MATCH_COUNT_EN to add the saturating match_count output.
module seq_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               match
`ifdef MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_count
`endif
);

  // Reject parameter sets the datapath cannot represent.
  if (MAX_LEN < 2 || MAX_LEN > 32 || CNT_W < 1) begin : g_bad_params
    $error("seq_pattern_detector: illegal MAX_LEN or CNT_W");
  end

  // The oldest window bit is only ever looked at through hist_shift, so the
  // stored history is one bit shorter than the comparison window.
  logic [MAX_LEN-2:0] hist_reg, hist_next;
  logic [MAX_LEN-1:0] pattern_reg, pattern_next;
  logic [MAX_LEN-1:0] hist_shift, len_mask;
  logic [LEN_W-1:0]   fill_reg, fill_next, fill_inc;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic               overlap_reg, overlap_next;
  logic               match_reg, match_next;
  logic               cfg_ok, load_accept, hit;

  assign cfg_ok      = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign load_accept = cfg_load && cfg_ok;
  assign hist_shift  = {hist_reg, in_bit};
  assign fill_inc    = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + LEN_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign len_mask[gi] = (len_reg > LEN_W'(gi));
    end
  endgenerate

  assign hit = (fill_inc >= len_reg) && (((hist_shift ^ pattern_reg) & len_mask) == '0);

  always_comb begin
    hist_next    = hist_reg;
    fill_next    = fill_reg;
    pattern_next = pattern_reg;
    len_next     = len_reg;
    overlap_next = overlap_reg;
    match_next   = 1'b0;
    if (load_accept) begin
      pattern_next = cfg_pattern;
      len_next     = cfg_len;
      overlap_next = cfg_overlap;
      hist_next    = '0;
      fill_next    = '0;
    end else if (in_valid) begin
      hist_next  = hist_shift[MAX_LEN-2:0];
      match_next = hit;
      // Non-overlapping mode forces the next match to use entirely fresh bits.
      fill_next  = (hit && !overlap_reg) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg    <= '0;
      fill_reg    <= '0;
      pattern_reg <= '1;
      len_reg     <= LEN_W'(3);
      overlap_reg <= 1'b1;
      match_reg   <= 1'b0;
    end else begin
      hist_reg    <= hist_next;
      fill_reg    <= fill_next;
      pattern_reg <= pattern_next;
      len_reg     <= len_next;
      overlap_reg <= overlap_next;
      match_reg   <= match_next;
    end
  end

  assign match = match_reg;

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (load_accept)
      count_next = '0;
    else if (match_next && (count_reg != '1))
      count_next = count_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_reg <= '0;
    else     count_reg <= count_next;
  end

  assign match_count = count_reg;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed scenarios plus randomized traffic
// checked against a queue-based reference model. Honors MATCH_COUNT_EN.
module tb_seq_pattern_detector;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_bit = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               match;
`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0]   match_count;
`endif

  always #5 clk = ~clk;

  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .match(match)
`ifdef MATCH_COUNT_EN
    , .match_count(match_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int txn = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: list of bits received since the last clear, compared
  // against the newest len bits directly.
  bit               q[$];
  int               m_len;
  bit [MAX_LEN-1:0] m_pat;
  bit               m_ov;
  int               m_cnt;
  bit               m_match;

  function automatic void model_reset();
    q.delete();
    m_len = 3; m_pat = '1; m_ov = 1'b1; m_cnt = 0; m_match = 1'b0;
  endfunction

  function automatic void model_step(bit v, bit b, bit ld, bit [MAX_LEN-1:0] pat, int len, bit ov);
    bit hit;
    m_match = 1'b0;
    if (ld && len >= 1 && len <= MAX_LEN) begin
      m_pat = pat; m_len = len; m_ov = ov; q.delete(); m_cnt = 0;
    end else if (v) begin
      q.push_back(b);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      hit = (q.size() >= m_len);
      if (hit)
        for (int k = 0; k < m_len; k++)
          if (q[q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      m_match = hit;
      if (hit && !m_ov) q.delete();
    end
    if (m_match && m_cnt < CNT_MAX) m_cnt++;
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    chk({tag, "_match"}, match, 0);
`ifdef MATCH_COUNT_EN
    chk({tag, "_count"}, match_count, 0);
`endif
    $display("txn %0d %s reset match=%b", txn, tag, match);
    txn++;
  endtask

  // One clock of stimulus; exp < 0 means take the expectation from the model.
  task automatic step(input string tag, input bit v, input bit b, input bit ld,
                      input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                      input bit ov, input int exp);
    @(negedge clk);
    rst = 1'b0; in_valid = v; in_bit = b; cfg_load = ld;
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
    @(posedge clk);
    model_step(v, b, ld, pat, int'(len), ov);
    #1;
    chk(tag, match, (exp < 0) ? 32'(m_match) : 32'(exp));
`ifdef MATCH_COUNT_EN
    chk({tag, "_count"}, match_count, m_cnt);
`endif
    $display("txn %0d %s v=%b b=%b ld=%b len=%0d match=%b", txn, tag, v, b, ld, len, match);
    txn++;
  endtask

  task automatic bit_in(input string tag, input bit b, input int exp);
    step(tag, 1'b1, b, 1'b0, '0, '0, 1'b0, exp);
  endtask

  task automatic gap(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 0);
  endtask

  initial begin
    bit seq1[8] = '{1, 1, 1, 1, 0, 1, 1, 1};
    bit exp1[8] = '{0, 0, 1, 1, 0, 0, 0, 1};
    bit seq3[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit exp3a[7] = '{0, 0, 0, 1, 0, 0, 1};
    bit exp3b[7] = '{0, 0, 0, 1, 0, 0, 0};

    // Default three-ones overlapping detector.
    do_reset("t1_rst");
    for (int i = 0; i < 8; i++) bit_in("t1", seq1[i], exp1[i]);

    // Non-overlapping 111.
    step("t2_load", 1'b0, 1'b0, 1'b1, 8'b111, 4'd3, 1'b0, 0);
    for (int i = 0; i < 6; i++) bit_in("t2", 1'b1, (i == 2 || i == 5) ? 1 : 0);

    // 1011 with and without overlap.
    step("t3a_load", 1'b0, 1'b0, 1'b1, 8'b1011, 4'd4, 1'b1, 0);
    for (int i = 0; i < 7; i++) bit_in("t3a", seq3[i], exp3a[i]);
    step("t3b_load", 1'b0, 1'b0, 1'b1, 8'b1011, 4'd4, 1'b0, 0);
    for (int i = 0; i < 7; i++) bit_in("t3b", seq3[i], exp3b[i]);

    // Gaps in in_valid between bits.
    do_reset("t4_rst");
    for (int i = 0; i < 3; i++) begin
      bit_in("t4", 1'b1, (i == 2) ? 1 : 0);
      gap("t4_gap");
      gap("t4_gap");
    end

    // Accepted load drops the concurrent bit and clears history.
    do_reset("t5_rst");
    bit_in("t5", 1'b1, 0);
    bit_in("t5", 1'b1, 0);
    step("t5_load", 1'b1, 1'b1, 1'b1, 8'b111, 4'd3, 1'b1, 0);
    bit_in("t5", 1'b1, 0);
    bit_in("t5", 1'b1, 0);
    bit_in("t5", 1'b1, 1);
    // Illegal length: load ignored, concurrent bit still counts.
    do_reset("t5b_rst");
    step("t5b_load0", 1'b1, 1'b1, 1'b1, 8'b0, 4'd0, 1'b0, 0);
    bit_in("t5b", 1'b1, 0);
    bit_in("t5b", 1'b1, 1);
    bit_in("t5b", 1'b1, 1);
    step("t5b_load9", 1'b1, 1'b1, 1'b1, 8'b0, 4'd9, 1'b0, 1);

`ifdef MATCH_COUNT_EN
    // Counter saturation and reset.
    do_reset("t6_rst");
    for (int i = 0; i < 7; i++) bit_in("t6", 1'b1, (i >= 2) ? 1 : 0);
    chk("t6_sat", match_count, 3);
    do_reset("t6_rst2");
`endif

    // Randomized traffic against the model.
    do_reset("rnd_rst");
    for (int n = 0; n < 800; n++) begin
      int r;
      bit ld;
      logic [LEN_W-1:0] len;
      r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset("rnd_rst");
      end else begin
        ld = (r < 6);
        if ($urandom_range(0, 7) == 0) len = LEN_W'(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15));
        else len = LEN_W'($urandom_range(1, 4 + 4 * $urandom_range(0, 1)));
        step("rnd", ($urandom_range(0, 3) != 0), 1'($urandom), ld,
             MAX_LEN'($urandom), len, 1'($urandom), -1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
